// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus between NUM_REQ producers, the round-robin arbiter and the FIFO write port.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          full;
  logic                          half_full;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic [GW-1:0]                 gnt_id;
  logic                          busy;

  // Arbiter side
  modport slave (
    input  req_valid, req_data, full, half_full,
    output req_ready, wr_en, wr_data, gnt_id, busy
  );

  // Producers and FIFO side
  modport master (
    output req_valid, req_data, full, half_full,
    input  req_ready, wr_en, wr_data, gnt_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, with bounded
// bursts that collapse to single beats when the FIFO is half full at grant time.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic             wr_clk,
  input  logic             wr_rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state_q;
  logic [GW-1:0]         gnt_id_q;
  logic [GW-1:0]         last_gnt_q;
  logic [3:0]            beat_cnt_q;
  logic [3:0]            burst_lim_q;
  logic                  busy_q;

  logic [GW-1:0]         next_gnt_d;
  logic                  any_valid_d;
  logic                  wr_en_d;
  logic [NUM_REQ-1:0]    ready_d;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_arr[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign ready_d[gi]  = busy_q && (gnt_id_q == GW'(gi)) && !bus.full;
    end
  endgenerate

  // Rotating search starting just after the last grantee, so it gets lowest priority.
  always_comb begin
    next_gnt_d = last_gnt_q;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req_valid[GW'((int'(last_gnt_q) + k) % NUM_REQ)])
        next_gnt_d = GW'((int'(last_gnt_q) + k) % NUM_REQ);
    end
  end

  assign any_valid_d = |bus.req_valid;
  assign wr_en_d     = busy_q && bus.req_valid[gnt_id_q] && !bus.full;

  assign bus.req_ready = ready_d;
  assign bus.wr_en     = wr_en_d;
  assign bus.wr_data   = data_arr[gnt_id_q];
  assign bus.gnt_id    = gnt_id_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state_q     <= IDLE;
      gnt_id_q    <= '0;
      last_gnt_q  <= GW'(NUM_REQ - 1);
      beat_cnt_q  <= '0;
      burst_lim_q <= 4'(BURST_LEN);
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid_d) begin
            state_q     <= GRANT;
            busy_q      <= 1'b1;
            gnt_id_q    <= next_gnt_d;
            beat_cnt_q  <= '0;
            burst_lim_q <= bus.half_full ? 4'd1 : 4'(BURST_LEN);
          end
        end
        GRANT: begin
          // A dropped valid ends the burst; a full stall simply holds here.
          if (!bus.req_valid[gnt_id_q]) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            last_gnt_q <= gnt_id_q;
          end else if (wr_en_d) begin
            if (beat_cnt_q + 4'd1 == burst_lim_q) begin
              state_q    <= IDLE;
              busy_q     <= 1'b0;
              last_gnt_q <= gnt_id_q;
            end
            beat_cnt_q <= beat_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule
